// File: rtl/tnn_seq_classifier_pkg.sv
// rtl/tnn_seq_classifier_pkg.sv - shared state encodings, width helpers and ternary weight decode
package tnn_seq_classifier_pkg;

  typedef enum logic [1:0] {
    ST_HID  = 2'd0,
    ST_OUT  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int acc_width(input int feat_cnt, input int feat_bits);
    return $clog2(feat_cnt * ((1 << feat_bits) - 1) + 1) + 1;
  endfunction

  function automatic int score_width(input int hidden_cnt);
    return $clog2(hidden_cnt + 1) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Both mask bits set decodes to zero, same as neither set.
  function automatic logic signed [1:0] ternary(input logic pos, input logic neg);
    case ({pos, neg})
      2'b10:   return 2'sb01;
      2'b01:   return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/tnn_seq_classifier_argmax.sv
// rtl/tnn_seq_classifier_argmax.sv - combinational signed argmax, lowest index wins ties
module tnn_argmax
  import tnn_seq_classifier_pkg::*;
#(
  parameter int CLASS_CNT = 6,
  parameter int SCORE_W   = 7,
  parameter int IDX_W     = idx_width(CLASS_CNT)
) (
  input  logic [CLASS_CNT*SCORE_W-1:0] scores,
  output logic [IDX_W-1:0]             index
);

  logic signed [SCORE_W-1:0] best;

  // Strict greater-than keeps the earlier class on a tie.
  always_comb begin
    best  = $signed(scores[SCORE_W-1:0]);
    index = '0;
    for (int c = 1; c < CLASS_CNT; c++) begin
      if ($signed(scores[c*SCORE_W +: SCORE_W]) > best) begin
        best  = $signed(scores[c*SCORE_W +: SCORE_W]);
        index = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/tnn_seq_classifier.sv
// rtl/tnn_seq_classifier.sv - bit-serial two-layer ternary classifier: FSM, accumulators, scores
module tnn_seq_classifier
  import tnn_seq_classifier_pkg::*;
#(
  parameter int FEAT_CNT   = 12,
  parameter int HIDDEN_CNT = 40,
  parameter int FEAT_BITS  = 4,
  parameter int CLASS_CNT  = 6,
  parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  W1_POS = '0,
  parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  W1_NEG = '0,
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] W2_POS = '0,
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] W2_NEG = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FEAT_BITS*FEAT_CNT-1:0] data,
  output logic [$clog2(CLASS_CNT)-1:0]  prediction,
  output logic                          done
);

  localparam int AW = acc_width(FEAT_CNT, FEAT_BITS);
  localparam int SW = score_width(HIDDEN_CNT);
  localparam int CW = idx_width((FEAT_CNT > HIDDEN_CNT) ? FEAT_CNT : HIDDEN_CNT);
  localparam int PW = $clog2(CLASS_CNT);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic signed [AW-1:0]  acc      [HIDDEN_CNT];
  logic signed [AW-1:0]  acc_next [HIDDEN_CNT];
  logic [HIDDEN_CNT-1:0] hidden;
  logic signed [SW-1:0]  score      [CLASS_CNT];
  logic signed [SW-1:0]  score_next [CLASS_CNT];
  logic [SW*CLASS_CNT-1:0] score_flat;
  logic [PW-1:0]         best_idx;
  logic [FEAT_BITS-1:0]  feat;
  logic signed [AW-1:0]  feat_ext;
  logic                  hid_bit;
  logic signed [1:0]     w1_sel;
  logic signed [1:0]     w2_sel;

  // The shared counter selects the current feature in HID and the current hidden bit in OUT.
  always_comb begin
    feat    = '0;
    hid_bit = 1'b0;
    for (int f = 0; f < FEAT_CNT; f++)
      if (cnt == CW'(f)) feat = data[f*FEAT_BITS +: FEAT_BITS];
    for (int h = 0; h < HIDDEN_CNT; h++)
      if (cnt == CW'(h)) hid_bit = hidden[h];
  end

  assign feat_ext = AW'(feat);

  always_comb begin
    w1_sel = 2'sb00;
    for (int h = 0; h < HIDDEN_CNT; h++) begin
      w1_sel = 2'sb00;
      for (int f = 0; f < FEAT_CNT; f++)
        if (cnt == CW'(f)) w1_sel = ternary(W1_POS[h*FEAT_CNT+f], W1_NEG[h*FEAT_CNT+f]);
      case (w1_sel)
        2'sb01:  acc_next[h] = acc[h] + feat_ext;
        2'sb11:  acc_next[h] = acc[h] - feat_ext;
        default: acc_next[h] = acc[h];
      endcase
    end
  end

  always_comb begin
    w2_sel     = 2'sb00;
    score_flat = '0;
    for (int c = 0; c < CLASS_CNT; c++) begin
      w2_sel = 2'sb00;
      for (int h = 0; h < HIDDEN_CNT; h++)
        if (hid_bit && cnt == CW'(h)) w2_sel = ternary(W2_POS[c*HIDDEN_CNT+h], W2_NEG[c*HIDDEN_CNT+h]);
      score_next[c] = score[c] + {{(SW-2){w2_sel[1]}}, w2_sel};
      score_flat[c*SW +: SW] = score_next[c];
    end
  end

  tnn_argmax #(
    .CLASS_CNT (CLASS_CNT),
    .SCORE_W   (SW),
    .IDX_W     (PW)
  ) u_argmax (
    .scores (score_flat),
    .index  (best_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_HID;
      cnt        <= '0;
      hidden     <= '0;
      prediction <= '0;
      done       <= 1'b0;
      for (int h = 0; h < HIDDEN_CNT; h++) acc[h] <= '0;
      for (int c = 0; c < CLASS_CNT; c++) score[c] <= '0;
    end else begin
      case (state)
        ST_HID: begin
          for (int h = 0; h < HIDDEN_CNT; h++) acc[h] <= acc_next[h];
          if (cnt == CW'(FEAT_CNT - 1)) begin
            for (int h = 0; h < HIDDEN_CNT; h++) hidden[h] <= ~acc_next[h][AW-1];
            cnt   <= '0;
            state <= ST_OUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_OUT: begin
          for (int c = 0; c < CLASS_CNT; c++) score[c] <= score_next[c];
          if (cnt == CW'(HIDDEN_CNT - 1)) begin
            prediction <= best_idx;
            done       <= 1'b1;
            cnt        <= '0;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: ;
        default: begin
          cnt   <= '0;
          state <= ST_HID;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_seq_classifier.sv
// tb/tb_tnn_seq_classifier.sv - scoreboard bench over five weight configurations sharing one stimulus
module tb_tnn_seq_classifier;

  localparam int F = 12, H = 40, B = 4, C = 6;
  localparam int NW1 = F * H, NW2 = H * C;
  localparam int LAT = F + H;

  function automatic logic [NW1-1:0] gen_bits(input logic [31:0] seed);
    logic [31:0]    s;
    logic [NW1-1:0] v;
    s = seed;
    v = '0;
    for (int i = 0; i < NW1; i++) begin
      s = s ^ (s << 13);
      s = s ^ (s >> 17);
      s = s ^ (s << 5);
      v[i] = s[3];
    end
    return v;
  endfunction

  localparam logic [NW1-1:0] Z1     = '0;
  localparam logic [NW2-1:0] Z2     = '0;
  localparam logic [NW1-1:0] ONES1  = '1;
  localparam logic [NW2-1:0] W2_C3  = {{(2*H){1'b0}}, {H{1'b1}}, {(3*H){1'b0}}};
  localparam logic [NW1-1:0] W1N_H0 = NW1'(12'hFFF);
  localparam logic [NW2-1:0] W2P_T3 = (NW2'(1) << (5*H+0)) | (NW2'(1) << (5*H+2)) | (NW2'(1) << (2*H+1));
  localparam logic [NW1-1:0] RW1P   = gen_bits(32'h1234_5678);
  localparam logic [NW1-1:0] RW1N   = gen_bits(32'h0bad_cafe);
  localparam logic [NW1-1:0] RW2P_F = gen_bits(32'h2468_ace1);
  localparam logic [NW1-1:0] RW2N_F = gen_bits(32'h1357_9bdf);
  localparam logic [NW2-1:0] RW2P   = RW2P_F[NW2-1:0];
  localparam logic [NW2-1:0] RW2N   = RW2N_F[NW2-1:0];

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [F*B-1:0] data = '0;
  logic [2:0]   pred_zero, pred_c2, pred_c3, pred_c6, pred_rnd;
  logic         done_zero, done_c2, done_c3, done_c6, done_rnd;

  tnn_seq_classifier #(.W1_POS(Z1), .W1_NEG(Z1), .W2_POS(Z2), .W2_NEG(Z2)) u_zero (
    .clk(clk), .rst(rst), .data(data), .prediction(pred_zero), .done(done_zero));
  tnn_seq_classifier #(.W1_POS(Z1), .W1_NEG(Z1), .W2_POS(W2_C3), .W2_NEG(Z2)) u_c2 (
    .clk(clk), .rst(rst), .data(data), .prediction(pred_c2), .done(done_c2));
  tnn_seq_classifier #(.W1_POS(Z1), .W1_NEG(W1N_H0), .W2_POS(W2P_T3), .W2_NEG(Z2)) u_c3 (
    .clk(clk), .rst(rst), .data(data), .prediction(pred_c3), .done(done_c3));
  tnn_seq_classifier #(.W1_POS(ONES1), .W1_NEG(ONES1), .W2_POS(W2P_T3), .W2_NEG(Z2)) u_c6 (
    .clk(clk), .rst(rst), .data(data), .prediction(pred_c6), .done(done_c6));
  tnn_seq_classifier #(.W1_POS(RW1P), .W1_NEG(RW1N), .W2_POS(RW2P), .W2_NEG(RW2N)) u_rnd (
    .clk(clk), .rst(rst), .data(data), .prediction(pred_rnd), .done(done_rnd));

  initial forever #5 clk = ~clk;

  typedef struct {
    int p_zero;
    int p_c2;
    int p_c3;
    int p_c6;
    int p_rnd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   edge_cnt = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int tern(input logic p, input logic n);
    if (p && !n) return 1;
    if (n && !p) return -1;
    return 0;
  endfunction

  function automatic int model_rnd(input logic [F*B-1:0] d);
    int acc, best;
    int hid [H];
    int sc  [C];
    for (int h = 0; h < H; h++) begin
      acc = 0;
      for (int f = 0; f < F; f++)
        acc += tern(RW1P[h*F+f], RW1N[h*F+f]) * int'(d[f*B +: B]);
      hid[h] = (acc >= 0) ? 1 : 0;
    end
    for (int c = 0; c < C; c++) begin
      sc[c] = 0;
      for (int h = 0; h < H; h++)
        if (hid[h] == 1) sc[c] += tern(RW2P[c*H+h], RW2N[c*H+h]);
    end
    best = 0;
    for (int c = 1; c < C; c++)
      if (sc[c] > sc[best]) best = c;
    return best;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (sb.size() > 0 && edge_cnt == LAT - 1)
      check("done_early", int'(done_zero), 0);
    if (done_zero && !prev_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("latency", edge_cnt, LAT);
        check("pred_zero", int'(pred_zero), mon_e.p_zero);
        check("pred_c2", int'(pred_c2), mon_e.p_c2);
        check("pred_c3", int'(pred_c3), mon_e.p_c3);
        check("pred_c6", int'(pred_c6), mon_e.p_c6);
        check("pred_rnd", int'(pred_rnd), mon_e.p_rnd);
        check("done_all", int'({done_c2, done_c3, done_c6, done_rnd}), 15);
      end
    end
    prev_done = done_zero;
  end

  task automatic start(input logic [F*B-1:0] d);
    @(negedge clk);
    rst  = 1'b1;
    data = d;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_zero) break;
    end
    if (!done_zero) begin
      check("timeout", 0, 1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [F*B-1:0] d, input int p_c3);
    exp_t e;
    e.p_zero = 0;
    e.p_c2   = 3;
    e.p_c3   = p_c3;
    e.p_c6   = 5;
    e.p_rnd  = model_rnd(d);
    sb.push_back(e);
    start(d);
    wait_done();
  endtask

  logic [F*B-1:0] d;

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset_done", int'(done_zero), 0);
    check("reset_pred", int'(pred_zero), 0);
    check("reset_done_c6", int'(done_c6), 0);

    run('0, 5);
    run({F{4'hF}}, 2);
    run(48'h1234_5678_9abc, 2);

    // Asynchronous clear of a finished run, away from any clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_done_c2", int'(done_c2), 0);
    check("async_pred_c2", int'(pred_c2), 0);
    check("async_pred_c6", int'(pred_c6), 0);

    // Abort a run at edge 20, then restart it.
    start(48'h0f0f_0f0f_0f0f);
    repeat (20) @(posedge clk);
    run(48'h0f0f_0f0f_0f0f, 2);

    // Hold in DONE while data toggles.
    run('0, 5);
    d = data;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      data = ~data;
    end
    check("hold_pred_zero", int'(pred_zero), 0);
    check("hold_pred_c2", int'(pred_c2), 3);
    check("hold_pred_c3", int'(pred_c3), 5);
    check("hold_pred_c6", int'(pred_c6), 5);
    check("hold_pred_rnd", int'(pred_rnd), model_rnd(d));
    check("hold_done", int'({done_zero, done_c2, done_c3, done_c6, done_rnd}), 31);

    for (int i = 0; i < 1000; i++) begin
      d = {16'($urandom), 32'($urandom)};
      run(d, (d == '0) ? 5 : 2);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
